// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath widths, the canonical NOP,
// the fetch FSM state type and the fetch/decode pipeline register payload.
package riscv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    // Fetch/decode pipeline register contents
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
        logic            valid;
    } fd_reg_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus.
//   req/addr/ready    : request handshake (fetch -> memory)
//   rvalid/rdata/rready: response handshake (memory -> fetch)
// master = fetch stage, slave = instruction memory.
interface instruction_fetch_if;
    import riscv_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic            rvalid;
    logic [ILEN-1:0] rdata;
    logic            rready;

    modport master (
        output req, addr, rready,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, addr, rready,
        output ready, rvalid, rdata
    );

endinterface

// File: rtl/ifetch_perf_counters.sv
// Fetch-stage performance counters (wrap at 2^32, synchronous active-low reset).
//   i_clk, i_rst_n  : clock, synchronous active-low reset
//   i_fetch         : a valid instruction was loaded into fetch/decode this cycle
//   i_flush         : a redirect was seen this cycle
//   o_fetch_count   : number of loaded instructions
//   o_flush_count   : number of redirect cycles
module ifetch_perf_counters (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fetch,
    input  logic        i_flush,
    output logic [31:0] o_fetch_count,
    output logic [31:0] o_flush_count
);

    localparam int unsigned CNT_W = 32;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_fetch_count <= '0;
            o_flush_count <= '0;
        end else begin
            if (i_fetch) o_fetch_count <= o_fetch_count + CNT_W'(1);
            if (i_flush) o_flush_count <= o_flush_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding word
// request at a time to instruction memory and fills the fetch/decode register.
// Optional feature macro: IFETCH_PERF_CNT_EN (adds fetch/flush counters).
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_stall            : hold fetch/decode register (blocks response acceptance)
//   i_redirect/_pc     : taken-branch flush and new fetch target
//   imem               : instruction-memory request/response bus (master)
//   o_pc/o_instruction/o_valid : fetch/decode register (registered)
//   o_fetch_count/o_flush_count: perf counters (only with IFETCH_PERF_CNT_EN)
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_stall,
    input  logic                i_redirect,
    input  logic [XLEN-1:0]     i_redirect_pc,
    instruction_fetch_if.master imem,
    output logic [XLEN-1:0]     o_pc,
    output logic [ILEN-1:0]     o_instruction,
    output logic                o_valid
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]         o_fetch_count,
    output logic [31:0]         o_flush_count
`endif
);

    localparam logic [1:0] S_ISSUE = 2'(ISSUE);
    localparam logic [1:0] S_WAIT  = 2'(WAIT);
    localparam logic [1:0] S_DROP  = 2'(DROP);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    fd_reg_t         fd_q, fd_d;
    logic [XLEN-1:0] redirect_tgt;
    logic            req_hs;
    logic            rsp_hs;
    logic            load;

    assign redirect_tgt = {i_redirect_pc[XLEN-1:2], 2'b00};

    // Next-state, bus handshake and fetch/decode register update
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        imem.req    = 1'b0;
        imem.addr   = pc_q;
        imem.rready = 1'b0;
        req_hs      = 1'b0;
        rsp_hs      = 1'b0;
        load        = 1'b0;

        case (state_q)
            S_ISSUE: begin
                imem.req = i_rst_n && !i_redirect;
                req_hs   = imem.req && imem.ready;
                if (i_redirect) begin
                    pc_d = redirect_tgt;
                end else if (req_hs) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // A redirect must still drain the response even when stalled
                imem.rready = i_rst_n && (!i_stall || i_redirect);
                rsp_hs      = imem.rready && imem.rvalid;
                if (i_redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = rsp_hs ? S_ISSUE : S_DROP;
                end else if (rsp_hs) begin
                    load    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_DROP: begin
                // Stale response is swallowed; leaving as soon as it arrives
                // (even alongside a new redirect) avoids waiting on a response
                // that will never come.
                imem.rready = i_rst_n;
                rsp_hs      = imem.rready && imem.rvalid;
                if (i_redirect) pc_d = redirect_tgt;
                if (rsp_hs) state_d = S_ISSUE;
            end
            default: begin
                state_d = S_ISSUE;
            end
        endcase

        // Fetch/decode register: flush > stall > load > bubble
        fd_d.pc    = fd_q.pc;
        fd_d.insn  = NOP_INSN;
        fd_d.valid = 1'b0;
        if (i_redirect) begin
            fd_d.pc = fd_q.pc;
        end else if (i_stall) begin
            fd_d = fd_q;
        end else if (load) begin
            fd_d.pc    = req_pc_q;
            fd_d.insn  = imem.rdata;
            fd_d.valid = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_ISSUE;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            fd_q.pc    <= '0;
            fd_q.insn  <= NOP_INSN;
            fd_q.valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            fd_q     <= fd_d;
        end
    end

    assign o_pc          = fd_q.pc;
    assign o_instruction = fd_q.insn;
    assign o_valid       = fd_q.valid;

`ifdef IFETCH_PERF_CNT_EN
    ifetch_perf_counters u_perf (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_fetch       (load),
        .i_flush       (i_redirect),
        .o_fetch_count (o_fetch_count),
        .o_flush_count (o_flush_count)
    );
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table followed by
// randomized traffic against a transaction-level reference model.
module tb_instruction_fetch;
    import riscv_pkg::*;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          NRAND  = 3000;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_stall;
    logic        i_redirect;
    logic [63:0] i_redirect_pc;
    logic [63:0] o_pc;
    logic [31:0] o_instruction;
    logic        o_valid;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] o_fetch_count;
    logic [31:0] o_flush_count;
`endif

    instruction_fetch_if imem ();

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .imem          (imem),
        .o_pc          (o_pc),
        .o_instruction (o_instruction),
        .o_valid       (o_valid)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .o_fetch_count (o_fetch_count),
        .o_flush_count (o_flush_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic        rst_n, stall, redir;
        logic [63:0] rpc;
        logic        ready, rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_rready;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_insn;
    } vec_t;

    // Memory contents: a fixed scramble of the address
    function automatic logic [31:0] word_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
    endfunction

    function automatic vec_t mk(
        input logic rst_n, input logic stall, input logic redir, input logic [63:0] rpc,
        input logic ready, input logic rvalid, input logic [31:0] rdata,
        input logic e_req, input logic [63:0] e_addr, input logic e_rready,
        input logic e_valid, input logic [63:0] e_pc, input logic [31:0] e_insn);
        vec_t v;
        v.rst_n = rst_n; v.stall = stall; v.redir = redir; v.rpc = rpc;
        v.ready = ready; v.rvalid = rvalid; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_rready = e_rready;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_insn = e_insn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state (transaction level)
    logic [63:0] m_pc, m_req_pc, m_out_pc;
    logic [31:0] m_out_insn;
    logic        m_out_valid, m_busy, m_stale;
    int unsigned m_fetch, m_flush;
    // Memory environment state
    logic        mem_pend;
    logic [63:0] mem_addr;
    int unsigned mem_dly;

    task automatic model_reset();
        m_pc = RST_PC; m_req_pc = '0; m_out_pc = '0; m_out_insn = NOP; m_out_valid = 1'b0;
        m_busy = 1'b0; m_stale = 1'b0; m_fetch = 0; m_flush = 0;
        mem_pend = 1'b0; mem_addr = '0; mem_dly = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".valid"}, 64'(o_valid), 64'(m_out_valid));
        chk({tag, ".pc"}, o_pc, m_out_pc);
        chk({tag, ".insn"}, 64'(o_instruction), 64'(m_out_insn));
`ifdef IFETCH_PERF_CNT_EN
        chk({tag, ".fetch_cnt"}, 64'(o_fetch_count), 64'(m_fetch));
        chk({tag, ".flush_cnt"}, 64'(o_flush_count), 64'(m_flush));
`endif
    endtask

    vec_t vecs[$];

    initial begin
        logic [63:0] top_pc;
        i_rst_n = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
        imem.ready = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        top_pc = 64'hFFFF_FFFF_FFFF_FFFC;

        // rst stall redir rpc ready rvalid rdata | req addr rready | valid pc insn
        vecs.push_back(mk(0,0,0,0,0,0,0,                       0,0,0,            0,0,NOP));
        vecs.push_back(mk(1,0,0,0,1,0,0,                       1,64'h1000,0,     0,0,NOP));
        vecs.push_back(mk(1,0,0,0,1,1,word_of(64'h1000),       0,0,1,            1,64'h1000,word_of(64'h1000)));
        vecs.push_back(mk(1,1,0,0,1,0,0,                       1,64'h1004,0,     1,64'h1000,word_of(64'h1000)));
        vecs.push_back(mk(1,1,0,0,1,1,word_of(64'h1004),       0,0,0,            1,64'h1000,word_of(64'h1000)));
        vecs.push_back(mk(1,1,0,0,1,1,word_of(64'h1004),       0,0,0,            1,64'h1000,word_of(64'h1000)));
        vecs.push_back(mk(1,0,0,0,1,1,word_of(64'h1004),       0,0,1,            1,64'h1004,word_of(64'h1004)));
        vecs.push_back(mk(1,0,0,0,0,0,0,                       1,64'h1008,0,     0,64'h1004,NOP));
        vecs.push_back(mk(1,0,0,0,0,0,0,                       1,64'h1008,0,     0,64'h1004,NOP));
        vecs.push_back(mk(1,0,0,0,1,0,0,                       1,64'h1008,0,     0,64'h1004,NOP));
        vecs.push_back(mk(1,0,1,64'h2002,1,0,0,                0,0,1,            0,64'h1004,NOP));
        vecs.push_back(mk(1,0,0,0,1,0,0,                       0,0,1,            0,64'h1004,NOP));
        vecs.push_back(mk(1,0,0,0,1,1,32'hDEAD_BEEF,           0,0,1,            0,64'h1004,NOP));
        vecs.push_back(mk(1,0,0,0,1,0,0,                       1,64'h2000,0,     0,64'h1004,NOP));
        vecs.push_back(mk(1,0,0,0,1,1,word_of(64'h2000),       0,0,1,            1,64'h2000,word_of(64'h2000)));
        vecs.push_back(mk(1,1,0,0,1,0,0,                       1,64'h2004,0,     1,64'h2000,word_of(64'h2000)));
        vecs.push_back(mk(1,1,1,64'h3000,1,1,word_of(64'h2004),0,0,1,            0,64'h2000,NOP));
        vecs.push_back(mk(1,0,0,0,1,0,0,                       1,64'h3000,0,     0,64'h2000,NOP));
        vecs.push_back(mk(1,0,0,0,1,1,word_of(64'h3000),       0,0,1,            1,64'h3000,word_of(64'h3000)));
        vecs.push_back(mk(1,0,1,64'hFFFF_FFFF_FFFF_FFFF,1,0,0, 0,0,0,            0,64'h3000,NOP));
        vecs.push_back(mk(1,0,0,0,1,0,0,                       1,top_pc,0,       0,64'h3000,NOP));
        vecs.push_back(mk(1,0,0,0,1,1,word_of(top_pc),         0,0,1,            1,top_pc,word_of(top_pc)));
        vecs.push_back(mk(1,0,0,0,1,0,0,                       1,64'h0,0,        0,top_pc,NOP));
        vecs.push_back(mk(1,0,0,0,1,1,word_of(64'h0),          0,0,1,            1,64'h0,word_of(64'h0)));
        vecs.push_back(mk(1,0,0,0,1,0,0,                       1,64'h4,0,        0,64'h0,NOP));
        vecs.push_back(mk(0,0,0,0,1,0,0,                       0,0,0,            0,64'h0,NOP));
        vecs.push_back(mk(1,0,0,0,1,0,0,                       1,64'h1000,0,     0,64'h0,NOP));

        foreach (vecs[i]) begin
            @(negedge i_clk);
            i_rst_n = vecs[i].rst_n; i_stall = vecs[i].stall;
            i_redirect = vecs[i].redir; i_redirect_pc = vecs[i].rpc;
            imem.ready = vecs[i].ready; imem.rvalid = vecs[i].rvalid; imem.rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d.req", i), 64'(imem.req), 64'(vecs[i].e_req));
            chk($sformatf("v%0d.rready", i), 64'(imem.rready), 64'(vecs[i].e_rready));
            if (vecs[i].e_req) chk($sformatf("v%0d.addr", i), imem.addr, vecs[i].e_addr);
            @(posedge i_clk); #1;
            chk($sformatf("v%0d.valid", i), 64'(o_valid), 64'(vecs[i].e_valid));
            chk($sformatf("v%0d.pc", i), o_pc, vecs[i].e_pc);
            chk($sformatf("v%0d.insn", i), 64'(o_instruction), 64'(vecs[i].e_insn));
`ifdef IFETCH_PERF_CNT_EN
            if (i == 24) begin
                chk("v24.fetch_cnt", 64'(o_fetch_count), 64'd6);
                chk("v24.flush_cnt", 64'(o_flush_count), 64'd3);
            end
            if (i == 25) begin
                chk("v25.fetch_cnt", 64'(o_fetch_count), 64'd0);
                chk("v25.flush_cnt", 64'(o_flush_count), 64'd0);
            end
`endif
        end

        // Randomized phase, starting from a fresh reset
        @(negedge i_clk);
        i_rst_n = 1'b0; i_stall = 1'b0; i_redirect = 1'b0;
        imem.ready = 1'b0; imem.rvalid = 1'b0;
        @(posedge i_clk); #1;
        model_reset();
        check_regs("rand_rst");

        for (int c = 0; c < NRAND; c++) begin
            logic rst, stall, redir, ready, rvalid;
            logic [63:0] rpc;
            logic e_req, e_rready, m_req_hs, m_rsp_hs, d_req_hs, d_rsp_hs, ld;
            logic [63:0] d_addr;

            @(negedge i_clk);
            rst   = ($urandom_range(0, 249) != 0);
            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 9) == 0);
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            else
                rpc = {$urandom, $urandom};
            rvalid = mem_pend && (mem_dly == 0);
            i_rst_n = rst; i_stall = stall; i_redirect = redir; i_redirect_pc = rpc;
            imem.ready = ready; imem.rvalid = rvalid;
            imem.rdata = rvalid ? word_of(mem_addr) : $urandom;
            #1;

            e_req    = rst && !m_busy && !redir;
            e_rready = rst && m_busy && (m_stale || !stall || redir);
            chk($sformatf("r%0d.req", c), 64'(imem.req), 64'(e_req));
            chk($sformatf("r%0d.rready", c), 64'(imem.rready), 64'(e_rready));
            if (e_req) chk($sformatf("r%0d.addr", c), imem.addr, m_pc);

            d_req_hs = imem.req && imem.ready;
            d_rsp_hs = imem.rvalid && imem.rready;
            d_addr   = imem.addr;
            m_req_hs = e_req && ready;
            m_rsp_hs = e_rready && rvalid;

            @(posedge i_clk); #1;
            if (!rst) begin
                model_reset();
            end else begin
                ld = m_busy && !m_stale && m_rsp_hs && !redir;
                if (redir) begin
                    m_out_insn = NOP; m_out_valid = 1'b0;
                end else if (!stall) begin
                    if (ld) begin
                        m_out_pc = m_req_pc; m_out_insn = word_of(m_req_pc); m_out_valid = 1'b1;
                    end else begin
                        m_out_insn = NOP; m_out_valid = 1'b0;
                    end
                end
                if (ld) m_fetch++;
                if (redir) m_flush++;

                if (!m_busy) begin
                    m_busy = m_req_hs;
                end else if (m_rsp_hs) begin
                    m_busy = 1'b0; m_stale = 1'b0;
                end else if (redir) begin
                    m_stale = 1'b1;
                end

                if (redir) begin
                    m_pc = {rpc[63:2], 2'b00};
                end else if (m_req_hs) begin
                    m_req_pc = m_pc;
                    m_pc = m_pc + 64'd4;
                end

                if (d_rsp_hs) mem_pend = 1'b0;
                else if (mem_pend && mem_dly > 0) mem_dly--;
                if (d_req_hs) begin
                    mem_pend = 1'b1; mem_addr = d_addr; mem_dly = $urandom_range(0, 3);
                end
            end
            check_regs($sformatf("r%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
